// File: rtl/softmax_scheduler.sv
// rtl/softmax_scheduler.sv - round-robin scheduler sharing one softmax engine among requesters
// Holds the granted operand on the engine input for the whole operation and bounds the wait with a watchdog.
module softmax_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int LANES       = 8,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*LANES*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]                resp_valid,
    input  logic [NUM_REQ-1:0]                resp_ready,
    output logic [LANES*DATA_W-1:0]           resp_data,
    output logic                              resp_err,
    output logic [LANES*DATA_W-1:0]           sm_data_in,
    output logic                              sm_valid_in,
    input  logic                              sm_ready_in,
    input  logic [LANES*DATA_W-1:0]           sm_data_out,
    input  logic                              sm_valid_out,
    output logic                              sm_ready_out,
    output logic                              busy,
    output logic [15:0]                       done_count
);

    localparam int VEC_W = LANES * DATA_W;
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               state, state_nxt;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     owner;
    logic [PTR_W-1:0]     grant;
    logic                 grant_vld;
    logic [VEC_W-1:0]     op_reg;
    logic [VEC_W-1:0]     res_reg;
    logic [WD_W-1:0]      wdog;
    logic                 wdog_last;

    assign wdog_last = (wdog == WD_W'(TIMEOUT_CYC - 1));

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant     = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        req_ready    = '0;
        resp_valid   = '0;
        sm_valid_in  = 1'b0;
        sm_ready_out = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_vld) begin
                    req_ready[grant] = 1'b1;
                    state_nxt        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                sm_valid_in = 1'b1;
                if (sm_ready_in) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                sm_ready_out = 1'b1;
                if (sm_valid_out || wdog_last) state_nxt = S_RESP;
            end
            S_RESP: begin
                resp_valid[owner] = 1'b1;
                if (resp_ready[owner]) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            op_reg     <= '0;
            res_reg    <= '0;
            resp_err   <= 1'b0;
            wdog       <= '0;
            done_count <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        op_reg <= req_data[int'(grant)*VEC_W +: VEC_W];
                        owner  <= grant;
                    end
                end
                S_ISSUE: begin
                    if (sm_ready_in) wdog <= '0;
                end
                S_WAIT: begin
                    // A result arriving on the last watchdog cycle still wins.
                    if (sm_valid_out) begin
                        res_reg  <= sm_data_out;
                        resp_err <= 1'b0;
                    end else if (wdog_last) begin
                        res_reg  <= '0;
                        resp_err <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready[owner]) begin
                        done_count <= done_count + 16'd1;
                        if (owner == PTR_W'(NUM_REQ - 1)) rr_ptr <= '0;
                        else                              rr_ptr <= owner + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sm_data_in = op_reg;
    assign resp_data  = res_reg;
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_softmax_scheduler.sv
// tb/tb_softmax_scheduler.sv - self-checking bench for softmax_scheduler
// Engine model plus a transaction-level reference for grant order, latency, results and counters.
module tb_softmax_scheduler;

    localparam int NR    = 4;
    localparam int LN    = 8;
    localparam int DW    = 16;
    localparam int TO    = 64;
    localparam int VW    = LN * DW;
    localparam int NEVER = 1000;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*VW-1:0]  req_data;
    logic [NR-1:0]     resp_valid;
    logic [NR-1:0]     resp_ready;
    logic [VW-1:0]     resp_data;
    logic              resp_err;
    logic [VW-1:0]     sm_data_in;
    logic              sm_valid_in;
    logic              sm_ready_in;
    logic [VW-1:0]     sm_data_out;
    logic              sm_valid_out;
    logic              sm_ready_out;
    logic              busy;
    logic [15:0]       done_count;

    softmax_scheduler #(
        .NUM_REQ(NR), .LANES(LN), .DATA_W(DW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .sm_data_in(sm_data_in), .sm_valid_in(sm_valid_in), .sm_ready_in(sm_ready_in),
        .sm_data_out(sm_data_out), .sm_valid_out(sm_valid_out), .sm_ready_out(sm_ready_out),
        .busy(busy), .done_count(done_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // engine configuration (written by the stimulus) and engine-private state
    int           eng_lat   = 0;
    int           eng_stall = 0;
    int           eng_mode  = 0;
    logic [VW-1:0] exp_op   = '0;
    int           hold_errs = 0;
    int           stall_left;
    int           cnt;
    logic         pending;
    logic [VW-1:0] pend_data;

    int           m_rr   = 0;
    int           m_done = 0;

    function automatic logic [VW-1:0] eng_fn(input logic [VW-1:0] x, input int mode);
        logic [VW-1:0] c;
        if (mode == 1) c = {LN{16'h1000}};
        else           c = x ^ {LN{16'hA5C3}};
        return c;
    endfunction

    // Engine: optional ISSUE stall, result eng_lat cycles into WAIT; also checks operand stability.
    always @(negedge clk) begin
        if (rst) begin
            pending      = 1'b0;
            sm_valid_out = 1'b0;
            sm_ready_in  = 1'b1;
            sm_data_out  = '0;
            stall_left   = eng_stall;
        end else begin
            sm_valid_out = 1'b0;
            if (pending) begin
                if (sm_data_in !== exp_op) hold_errs++;
                if (cnt == 0) begin
                    sm_valid_out = 1'b1;
                    sm_data_out  = pend_data;
                    pending      = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (sm_valid_in) begin
                if (sm_data_in !== exp_op) hold_errs++;
                if (stall_left > 0) begin
                    sm_ready_in = 1'b0;
                    stall_left--;
                end else begin
                    sm_ready_in = 1'b1;
                    if (eng_lat < NEVER) begin
                        pending   = 1'b1;
                        cnt       = eng_lat;
                        pend_data = eng_fn(sm_data_in, eng_mode);
                    end
                end
            end else begin
                sm_ready_in = 1'b1;
                stall_left  = eng_stall;
            end
        end
    end

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int r = 0; r < NR; r++)
            for (int i = 0; i < LN; i++)
                req_data[(r*LN+i)*DW +: DW] = DW'($urandom);
    endtask

    function automatic int model_grant(input logic [NR-1:0] rv, input int rr);
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (rr + k) % NR;
            if (rv[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic run_txn(input string name, input logic [NR-1:0] rv, input logic [NR-1:0] rv_after,
                           input int lat, input int stall, input int hold, input int mode,
                           input int g, input int exp_lat, input logic exp_err, output int obs);
        int            cyc;
        int            bad;
        int            h0;
        logic [VW-1:0] exp_res;
        logic [VW-1:0] d0;
        logic [NR-1:0] v0;
        logic          e0;
        eng_lat   = lat;
        eng_stall = stall;
        eng_mode  = mode;
        exp_op    = req_data[g*VW +: VW];
        exp_res   = exp_err ? '0 : eng_fn(exp_op, mode);
        h0        = hold_errs;
        obs       = -1;
        req_valid = rv;
        resp_ready = '0;
        #1;
        chk({name, ".req_ready"}, VW'(req_ready), VW'(4'b0001 << g));
        step();
        req_valid = rv_after;
        cyc = 0;
        bad = 0;
        while (resp_valid == '0 && cyc < 300) begin
            if (req_ready != '0) bad++;
            rand_data();
            step();
            cyc++;
        end
        chk({name, ".latency"}, VW'(cyc), VW'(exp_lat));
        chk({name, ".resp_valid"}, VW'(resp_valid), VW'(4'b0001 << g));
        chk({name, ".resp_data"}, resp_data, exp_res);
        chk({name, ".resp_err"}, VW'(resp_err), VW'(exp_err));
        for (int r = 0; r < NR; r++) if (resp_valid[r]) obs = r;
        v0 = resp_valid;
        d0 = resp_data;
        e0 = resp_err;
        resp_ready = ~(4'b0001 << g);
        for (int i = 0; i < hold; i++) begin
            step();
            if (resp_valid !== v0 || resp_data !== d0 || resp_err !== e0 || busy !== 1'b1 || req_ready != '0)
                bad++;
        end
        chk({name, ".no_grant_and_stable"}, VW'(bad), '0);
        resp_ready = 4'hF;
        step();
        resp_ready = '0;
        m_done = (m_done + 1) % 65536;
        m_rr   = (g + 1) % NR;
        chk({name, ".done_count"}, VW'(done_count), VW'(m_done));
        chk({name, ".idle_after"}, VW'({busy, resp_valid}), '0);
        chk({name, ".operand_hold"}, VW'(hold_errs - h0), '0);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        step();
        chk("reset.ctrl", VW'({req_ready, resp_valid, resp_err, sm_valid_in, sm_ready_out, busy, done_count}), '0);
        chk("reset.data", resp_data | sm_data_in, '0);
        rst    = 1'b0;
        m_rr   = 0;
        m_done = 0;
    endtask

    typedef struct {
        logic [NR-1:0] rv;
        int            lat;
        int            stall;
        int            hold;
        int            mode;
        int            exp_grant;
        int            exp_lat;
        logic          exp_err;
    } vec_t;

    vec_t vecs[9];
    int   obs;
    int   tally[NR];

    initial begin
        vecs[0] = '{4'b0001, 4,     0, 0, 1, 0, 6,  1'b0};
        vecs[1] = '{4'b0001, 0,     2, 1, 0, 0, 4,  1'b0};
        vecs[2] = '{4'b1001, 3,     0, 0, 0, 3, 5,  1'b0};
        vecs[3] = '{4'b1010, 1,     1, 3, 0, 1, 4,  1'b0};
        vecs[4] = '{4'b0011, 2,     0, 0, 0, 0, 4,  1'b0};
        vecs[5] = '{4'b1111, NEVER, 0, 2, 0, 1, 65, 1'b1};
        vecs[6] = '{4'b1111, 63,    0, 0, 0, 2, 65, 1'b0};
        vecs[7] = '{4'b1111, 64,    3, 0, 0, 3, 68, 1'b1};
        vecs[8] = '{4'b0110, 5,     0, 0, 0, 1, 7,  1'b0};

        req_data = '0;
        do_reset();

        for (int i = 0; i < 9; i++) begin
            rand_data();
            if (i == 0) req_data[0 +: VW] = {LN{16'h0100}};
            run_txn($sformatf("vec%0d", i), vecs[i].rv, vecs[i].rv, vecs[i].lat, vecs[i].stall,
                    vecs[i].hold, vecs[i].mode, vecs[i].exp_grant, vecs[i].exp_lat, vecs[i].exp_err, obs);
        end

        // fairness: all requesters valid, owner always ready
        do_reset();
        for (int r = 0; r < NR; r++) tally[r] = 0;
        for (int i = 0; i < 8; i++) begin
            int lat;
            lat = $urandom_range(0, 5);
            rand_data();
            run_txn($sformatf("fair%0d", i), 4'hF, 4'hF, lat, 0, 0, 0, i % NR, lat + 2, 1'b0, obs);
            if (obs >= 0) tally[obs]++;
        end
        for (int r = 0; r < NR; r++) chk($sformatf("fair.tally%0d", r), VW'(tally[r]), VW'(2));

        // back-pressure on requester 2 with 0 and 1 waiting, then 3 and 0 follow
        rand_data();
        run_txn("bp.pre", 4'b0010, 4'b0010, 1, 0, 0, 0, 1, 3, 1'b0, obs);
        rand_data();
        run_txn("bp.hold", 4'b0111, 4'b1011, 2, 0, 10, 0, 2, 4, 1'b0, obs);
        rand_data();
        run_txn("bp.next3", 4'b1011, 4'b1011, 0, 0, 0, 0, 3, 2, 1'b0, obs);
        rand_data();
        run_txn("bp.next0", 4'b0011, 4'b0011, 0, 0, 0, 0, 0, 2, 1'b0, obs);

        // randomized traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [NR-1:0] rv;
            int lat, stall, g, el, sel;
            logic err;
            rv    = NR'($urandom_range(1, 15));
            sel   = $urandom_range(0, 9);
            if (sel == 0)      lat = NEVER;
            else if (sel == 1) lat = $urandom_range(TO - 3, TO + 3);
            else               lat = $urandom_range(0, 8);
            stall = $urandom_range(0, 3);
            g     = model_grant(rv, m_rr);
            err   = (lat >= TO);
            el    = err ? (TO + 1 + stall) : (lat + 2 + stall);
            rand_data();
            run_txn($sformatf("rnd%0d", i), rv, NR'($urandom), lat, stall, $urandom_range(0, 4),
                    0, g, el, err, obs);
        end

        // reset in the middle of WAIT
        rand_data();
        eng_lat   = NEVER;
        eng_stall = 0;
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        for (int i = 0; i < 5; i++) step();
        chk("midrst.in_wait", VW'({busy, sm_ready_out}), VW'(2'b11));
        rst = 1'b1;
        step();
        chk("midrst.ctrl", VW'({req_ready, resp_valid, resp_err, sm_valid_in, sm_ready_out, busy, done_count}), '0);
        chk("midrst.data", resp_data | sm_data_in, '0);
        rst    = 1'b0;
        m_rr   = 0;
        m_done = 0;
        step();
        rand_data();
        run_txn("midrst.after", 4'b0010, 4'b0010, 3, 0, 0, 0, 1, 5, 1'b0, obs);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
